// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side bundle of the buffered UART transmitter.
// Producer drives wr_en/wr_data; the FIFO returns its level flags.
interface uart_tx_fifo_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic              overflow;

   modport master (
      output wr_en, wr_data,
      input  full, empty, count, overflow
   );

   modport slave (
      input  wr_en, wr_data,
      output full, empty, count, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered LSB-first UART transmitter.
// Define UART_TX_PARITY_EN to append an even-parity bit per frame.
module uart_tx_fifo #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_fifo_if.slave wr,
   output logic          busy,
   output logic          tx
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int NW = $clog2(DATA_W);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] DATA_LAST = NW'(DATA_W - 1);
   localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   state_t            state_q, state_d;
   logic [BW-1:0]     baud_q, baud_d;
   logic [NW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              full, empty;
   logic              push, pop, tick;
   logic [DATA_W-1:0] head;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   assign push  = wr.wr_en && !full;
   assign head  = mem_q[rd_ptr_q];
   assign tick  = (baud_q == BAUD_LAST);

   assign wr.full     = full;
   assign wr.empty    = empty;
   assign wr.count    = count_q;
   assign wr.overflow = ovf_q;
   assign busy        = (state_q != S_IDLE);
   assign tx          = tx_q;

   // A pop never frees a slot for a write in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = wr.wr_en && full;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);
   end

   always_comb begin
      state_d = state_q;
      baud_d  = tick ? '0 : baud_q + BW'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               sh_d    = head;
`ifdef UART_TX_PARITY_EN
               par_d   = ^head;
`endif
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               sh_d = sh_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + NW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // Chain straight into the next start bit.
                  if (!empty) begin
                     pop     = 1'b1;
                     sh_d    = head;
`ifdef UART_TX_PARITY_EN
                     par_d   = ^head;
`endif
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + NW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level follows the next state so tx stays a clean flop.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end
endmodule
